mystic_csr_rmw: RTL and testbench

Requester side of the CSR storage: executes Zicsr instructions (CSRRW/RS/RC and immediate forms) as read-modify-write sequences against the 4-stage-pipelined CSR block RAM. Sits between decode/execute and CSR storage. Returns the old CSR value for rd through a valid/ready response. One transaction in flight at a time.

---
 rtl/mystic_csr_rmw_pkg.sv | 34 +++
 rtl/mystic_csr_alu.sv | 20 ++
 rtl/mystic_csr_rmw.sv | 109 ++++++++++
 tb/tb_mystic_csr_rmw.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mystic_csr_rmw_pkg.sv
// Shared Zicsr definitions for the CSR read-modify-write requester: funct3 codes,
// FSM state encodings, read-only address field and the default storage latency.
package mystic_csr_rmw_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] RO_ADDR_FIELD = 2'b11;
  localparam int DEFAULT_RD_LATENCY = 4;

  // Set/clear forms with a zero source leave the CSR untouched, so no write is issued.
  function automatic logic wr_intent(input logic [2:0] f3, input logic rs1_is_x0,
                                     input logic [4:0] uimm);
    logic w;
    w = 1'b0;
    case (f3)
      F3_RW, F3_RWI:  w = 1'b1;
      F3_RS, F3_RC:   w = ~rs1_is_x0;
      F3_RSI, F3_RCI: w = (uimm != 5'd0);
      default:        w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mystic_csr_alu.sv
// Combinational CSR update: RW replaces, RS sets bits, RC clears bits.
module mystic_csr_alu
  import mystic_csr_rmw_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] src_i,
  output logic [XLEN-1:0] new_o
);

  always_comb begin
    new_o = old_i;
    if (op_i == F3_RW[1:0])      new_o = src_i;
    else if (op_i == F3_RS[1:0]) new_o = old_i | src_i;
    else if (op_i == F3_RC[1:0]) new_o = old_i & ~src_i;
  end

endmodule

// File: rtl/mystic_csr_rmw.sv
// Zicsr read-modify-write requester against a pipelined CSR RAM, one transaction at a time.
// Optional illegal-access checking is enabled by defining CSR_ILLEGAL_CHK_EN.
module mystic_csr_rmw
  import mystic_csr_rmw_pkg::*;
#(
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter int XLEN       = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [11:0]     req_addr_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic            req_rs1_is_x0_i,
  input  logic [4:0]      req_uimm_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_illegal_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic [XLEN-1:0] csr_rdata_i
);

  localparam int CNT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      op_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] src_q, src_d;
  logic            wr_en_q, wr_en_d;
  logic            illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] new_value;
  logic            accept;
  logic            rd_done;

  assign accept  = req_valid_i && (state_q == ST_IDLE);
  assign rd_done = (cnt_q == CNT_W'(RD_LATENCY));

  always_comb begin
    src_d   = req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_uimm_i} : req_rs1_i;
    wr_en_d = wr_intent(req_funct3_i, req_rs1_is_x0_i, req_uimm_i);
`ifdef CSR_ILLEGAL_CHK_EN
    illegal_d = (req_funct3_i[1:0] == 2'b00) ||
                ((req_addr_i[11:10] == RO_ADDR_FIELD) && wr_en_d);
`else
    illegal_d = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_READ;
      ST_READ:  if (rd_done) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= 2'b00;
      addr_q    <= 12'd0;
      src_q     <= '0;
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      old_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= req_funct3_i[1:0];
        addr_q    <= req_addr_i;
        src_q     <= src_d;
        wr_en_q   <= wr_en_d;
        illegal_q <= illegal_d;
        cnt_q     <= '0;
      end else if (state_q == ST_READ) begin
        // Storage returns data RD_LATENCY cycles after the first READ cycle.
        if (rd_done) old_q <= csr_rdata_i;
        else         cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  mystic_csr_alu #(.XLEN(XLEN)) u_alu (
    .op_i  (op_q),
    .old_i (old_q),
    .src_i (src_q),
    .new_o (new_value)
  );

  assign req_ready_o   = (state_q == ST_IDLE);
  assign csr_addr_o    = addr_q;
  assign csr_we_o      = (state_q == ST_WRITE) && wr_en_q && !illegal_q;
  assign csr_wdata_o   = (state_q == ST_WRITE) ? new_value : '0;
  assign rsp_valid_o   = (state_q == ST_RESP);
  assign rsp_illegal_o = (state_q == ST_RESP) && illegal_q;
  assign rsp_rdata_o   = ((state_q == ST_RESP) && !illegal_q) ? old_q : '0;

endmodule

// File: tb/tb_mystic_csr_rmw.sv
// Directed bench for mystic_csr_rmw with a 4-stage pipelined CSR RAM model.
// Illegal-access expectations follow CSR_ILLEGAL_CHK_EN.
module tb_mystic_csr_rmw;

  localparam int XLEN = 64;
  localparam int LAT  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_funct3 = 3'b000;
  logic [11:0]     req_addr = 12'd0;
  logic [XLEN-1:0] req_rs1 = '0;
  logic            req_x0 = 1'b0;
  logic [4:0]      req_uimm = 5'd0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;

  logic [XLEN-1:0] mem [0:4095];
  logic [XLEN-1:0] pipe [0:LAT-1];
  int              we_cnt = 0;
  logic [11:0]     last_waddr = 12'd0;
  logic [XLEN-1:0] last_wdata = '0;
  logic            we_prev = 1'b0;
  logic            we_consec = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mystic_csr_rmw #(.RD_LATENCY(LAT), .XLEN(XLEN)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_funct3_i    (req_funct3),
    .req_addr_i      (req_addr),
    .req_rs1_i       (req_rs1),
    .req_rs1_is_x0_i (req_x0),
    .req_uimm_i      (req_uimm),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_rdata_o     (rsp_rdata),
    .rsp_illegal_o   (rsp_illegal),
    .csr_we_o        (csr_we),
    .csr_addr_o      (csr_addr),
    .csr_wdata_o     (csr_wdata),
    .csr_rdata_i     (csr_rdata)
  );

  assign csr_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    pipe[0] <= mem[csr_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    we_prev <= csr_we;
    if (csr_we) begin
      mem[csr_addr] <= csr_wdata;
      we_cnt        <= we_cnt + 1;
      last_waddr    <= csr_addr;
      last_wdata    <= csr_wdata;
      if (we_prev) we_consec <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [11:0] a, input logic [XLEN-1:0] rs1,
                           input logic x0, input logic [4:0] uimm);
    req_funct3 = f3; req_addr = a; req_rs1 = rs1; req_x0 = x0; req_uimm = uimm;
    req_valid = 1'b1;
  endtask

  // Waits at negedges for rsp_valid, returns the number of negedges since the accept edge.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; break; end
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic [2:0] f3, input logic [11:0] a,
                         input logic [XLEN-1:0] rs1, input logic x0, input logic [4:0] uimm,
                         input logic [XLEN-1:0] exp_rdata, input int exp_we,
                         input logic [XLEN-1:0] exp_wdata, input logic exp_ill);
    int lat;
    int we0;
    @(negedge clk);
    drive_req(f3, a, rs1, x0, uimm);
    check({tag, "_rdy"}, XLEN'(req_ready), XLEN'(1'b1));
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    check({tag, "_lat"}, XLEN'(lat), XLEN'(LAT + 3));
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_ill"}, XLEN'(rsp_illegal), XLEN'(exp_ill));
    handshake();
    check({tag, "_nwe"}, XLEN'(we_cnt - we0), XLEN'(exp_we));
    if (exp_we != 0) begin
      check({tag, "_waddr"}, XLEN'(last_waddr), XLEN'(a));
      check({tag, "_wdata"}, last_wdata, exp_wdata);
    end
    check({tag, "_rdy_back"}, XLEN'(req_ready), XLEN'(1'b1));
    $display("txn %s f3=%b addr=%h rdata=%h ill=%b lat=%0d", tag, f3, a, exp_rdata, exp_ill, lat);
  endtask

  initial begin
    int lat;
    int we0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    mem[12'h300] = 64'hF0;
    mem[12'h301] = 64'h77;
    mem[12'h305] = 64'h1234;
    mem[12'hC00] = 64'h55;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", XLEN'(req_ready), XLEN'(1'b1));
    check("rst_rvalid", XLEN'(rsp_valid), XLEN'(1'b0));
    check("rst_rdata", rsp_rdata, '0);
    check("rst_ill", XLEN'(rsp_illegal), XLEN'(1'b0));
    check("rst_we", XLEN'(csr_we), XLEN'(1'b0));
    check("rst_addr", XLEN'(csr_addr), '0);
    check("rst_wdata", csr_wdata, '0);
    rst = 1'b0;

    run_req("rw340", 3'b001, 12'h340, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'h0, 1, 64'hDEAD_BEEF, 1'b0);
    run_req("reread340", 3'b010, 12'h340, 64'h0, 1'b1, 5'd0, 64'hDEAD_BEEF, 0, 64'h0, 1'b0);
    run_req("rs300", 3'b010, 12'h300, 64'h0F, 1'b0, 5'd0, 64'hF0, 1, 64'hFF, 1'b0);
    run_req("rc300", 3'b011, 12'h300, 64'h11, 1'b0, 5'd0, 64'hFF, 1, 64'hEE, 1'b0);
    run_req("rsi0_305", 3'b110, 12'h305, 64'hFFFF, 1'b0, 5'd0, 64'h1234, 0, 64'h0, 1'b0);
    run_req("rsx0_305", 3'b010, 12'h305, 64'hFFFF, 1'b1, 5'd0, 64'h1234, 0, 64'h0, 1'b0);
    run_req("rci300", 3'b111, 12'h300, 64'h0, 1'b0, 5'd6, 64'hEE, 1, 64'hE8, 1'b0);

    // Response back-pressure with a second request held pending.
    @(negedge clk);
    drive_req(3'b001, 12'h301, 64'h5, 1'b0, 5'd0);
    we0 = we_cnt;
    @(posedge clk); #1;
    drive_req(3'b101, 12'h301, 64'h0, 1'b0, 5'd3);
    @(negedge clk);
    check("busy_rdy", XLEN'(req_ready), XLEN'(1'b0));
    wait_rsp(lat);
    check("stall_lat", XLEN'(lat), XLEN'(LAT + 2));
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", XLEN'(rsp_valid), XLEN'(1'b1));
      check("stall_rdata", rsp_rdata, 64'h77);
      check("stall_rdy", XLEN'(req_ready), XLEN'(1'b0));
      @(negedge clk);
    end
    check("stall_nwe", XLEN'(we_cnt - we0), XLEN'(1));
    handshake();
    check("post_hs_rdy", XLEN'(req_ready), XLEN'(1'b1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    check("second_lat", XLEN'(lat), XLEN'(LAT + 3));
    check("second_rdata", rsp_rdata, 64'h5);
    handshake();
    check("second_nwe", XLEN'(we_cnt - we0), XLEN'(2));
    check("second_wdata", last_wdata, 64'h3);
    $display("txn stall rw301 then rwi301 completed");

    // Reset while READ counter is 2.
    @(negedge clk);
    drive_req(3'b001, 12'h340, 64'h1111, 1'b0, 5'd0);
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_rdy", XLEN'(req_ready), XLEN'(1'b1));
    check("rstmid_rvalid", XLEN'(rsp_valid), XLEN'(1'b0));
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) lat++;
    end
    check("rstmid_norsp", XLEN'(lat), XLEN'(0));
    check("rstmid_nwe", XLEN'(we_cnt - we0), XLEN'(0));
    $display("txn reset mid-read dropped");
    run_req("after_rst", 3'b001, 12'h340, 64'h2222, 1'b0, 5'd0, 64'hDEAD_BEEF, 1, 64'h2222, 1'b0);

`ifdef CSR_ILLEGAL_CHK_EN
    run_req("rw_c00", 3'b001, 12'hC00, 64'hAB, 1'b0, 5'd0, 64'h0, 0, 64'h0, 1'b1);
    run_req("f3_000", 3'b000, 12'h300, 64'h0, 1'b0, 5'd0, 64'h0, 0, 64'h0, 1'b1);
    run_req("rd_c00", 3'b010, 12'hC00, 64'h0, 1'b1, 5'd0, 64'h55, 0, 64'h0, 1'b0);
`else
    run_req("rw_c00", 3'b001, 12'hC00, 64'hAB, 1'b0, 5'd0, 64'h55, 1, 64'hAB, 1'b0);
    run_req("f3_000", 3'b000, 12'h300, 64'hFF, 1'b0, 5'd0, 64'hE8, 0, 64'h0, 1'b0);
`endif

    check("we_never_consec", XLEN'(we_consec), XLEN'(1'b0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
